muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide unit of the CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the execute stage.
- Drives the external 32x32 signed combinational multiplier (mul_a/mul_b -> mul_res), with a configurable multicycle window, and applies an unsigned correction for MULTU.
- Contains an iterative restoring divider, owns the HI/LO registers, and raises busy so the pipeline stalls MFHI/MFLO and new muldiv ops.

Parameters:
- MUL_CYCLES, 1, cycles allowed for the multiplier path to settle (legal range 1..4).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  operation request from execute stage.
- op_code  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
- op_a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- op_b  input  32  rt operand (divisor / multiplier).
- cancel  input  1  exception flush; aborts any operation in flight.
- busy  output  1  high whenever state != IDLE; op_ready = !busy.
- done  output  1  one-cycle pulse: HI/LO updated by a completed operation.
- hi  output  32  HI register.
- lo  output  32  LO register.
- mul_a  output  32  registered operand to the multiplier.
- mul_b  output  32  registered operand to the multiplier.
- mul_res  input  64  signed product from the multiplier.

Behaviour:
- Reset: state=IDLE; hi=lo=0; mul_a=mul_b=0; busy=0; done=0; divider registers cleared. Reset overrides everything, including mid-operation.
- Acceptance: an operation is accepted at edge E0 when op_valid && !busy && !cancel.
  - op_valid while busy is ignored; there is no queuing, so the requester holds the op.
  - Reserved op_codes are ignored: no state change, no done.
- States:
  - IDLE.
  - MUL: counter 0..MUL_CYCLES-1.
  - DIV: 32 iterations, counter 0..31.
  - FIX: 1 cycle for sign correction.
- MTHI/MTLO:
  - hi (or lo) := op_a at E0.
  - State stays IDLE, busy never asserts, done=1 in the following cycle.
- MULT/MULTU:
  - At E0: mul_a:=op_a, mul_b:=op_b, state:=MUL.
  - After MUL_CYCLES cycles in MUL, at edge E_MUL_CYCLES: {hi,lo} := product, state:=IDLE, done pulses in the next cycle.
  - MULT product = mul_res.
  - MULTU product = mul_res + (mul_a[31] ? mul_b<<32 : 0) + (mul_b[31] ? mul_a<<32 : 0), taken mod 2^64.
  - mul_a/mul_b hold their values until the next multiply is accepted.
- DIV/DIVU:
  - At E0, latch |a| and |b| (signed for DIV, raw for DIVU) and the operand signs; state:=DIV.
  - Each cycle performs one restoring shift-subtract step (33-bit partial remainder).
  - After 32 cycles, state:=FIX.
  - FIX: for DIV, the quotient is negated if the signs differ, and the remainder takes the dividend's sign. Then lo:=quotient, hi:=remainder at E33, state:=IDLE, done pulses.
  - busy is high for 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (natural wrap).
- Divide by zero (op_b==0):
  - hi/lo unchanged.
  - No DIV state is entered; done pulses in the cycle after E0, busy never asserts.
- cancel:
  - Sampled every edge. If state != IDLE, state:=IDLE at the next edge; hi/lo unchanged; no done.
  - cancel together with op_valid in IDLE drops the op, including MTHI/MTLO.
- done is never asserted in the same cycle as busy.

Test Plan:
- MULT a=0xFFFFFFFE, b=0x00000003, MUL_CYCLES=1 -> busy 1 cycle; hi=0xFFFFFFFF, lo=0xFFFFFFFA at E1; done pulses once.
- MULTU a=b=0xFFFFFFFF, MUL_CYCLES=3 -> busy 3 cycles; hi=0xFFFFFFFE, lo=0x00000001 at E3; mul_a/mul_b=0xFFFFFFFF throughout.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF at E33. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 with hi=lo=0x12345678 preloaded via MTHI/MTLO -> busy never high; done at E0+1; hi/lo still 0x12345678.
- DIV a=1000, b=3 with cancel asserted in the 10th busy cycle -> busy low the next cycle, no done, hi/lo unchanged. A second op_valid issued while busy is ignored.
- Reset asserted in the 2nd cycle of MULT with MUL_CYCLES=3 -> next cycle: hi=lo=0, busy=0, done=0, mul_a=mul_b=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: drives an external signed multiplier,
// runs a 32-step restoring divider and owns the HI/LO registers.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_res
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] ma_q, ma_d;
    logic [31:0] mb_q, mb_d;
    logic        uns_q, uns_d;
    logic        done_q, done_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    logic        accept;
    logic        abort;
    logic        is_mul;
    logic        is_div;
    logic        div_sgn;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [63:0] prod_u;

    assign accept  = op_valid && !cancel && (state_q == S_IDLE);
    assign abort   = cancel && (state_q != S_IDLE);
    assign is_mul  = (op_code == 3'd0) || (op_code == 3'd1);
    assign is_div  = ((op_code == 3'd2) || (op_code == 3'd3)) && (op_b != 32'd0);
    assign div_sgn = (op_code == 3'd2);
    assign a_abs   = (div_sgn && op_a[31]) ? -op_a : op_a;
    assign b_abs   = (div_sgn && op_b[31]) ? -op_b : op_b;

    // 33-bit partial remainder: remainder shifted left with next dividend bit
    assign div_sh  = {rem_q, quo_q[31]};
    assign div_ge  = div_sh >= {1'b0, dvs_q};

    // signed product reinterpreted as unsigned by adding back the sign weights
    assign prod_u  = mul_res
                   + (ma_q[31] ? {mb_q, 32'd0} : 64'd0)
                   + (mb_q[31] ? {ma_q, 32'd0} : 64'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            ma_q    <= 32'd0;
            mb_q    <= 32'd0;
            uns_q   <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            uns_q   <= uns_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = 5'd0;
                    if (accept && is_mul) state_d = S_MUL;
                    if (accept && is_div) state_d = S_DIV;
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_DIV: begin
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_FIX: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        ma_d   = ma_q;
        mb_d   = mb_q;
        uns_d  = uns_q;
        done_d = 1'b0;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (!abort) begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (op_code)
                            3'd0, 3'd1: begin
                                ma_d  = op_a;
                                mb_d  = op_b;
                                uns_d = op_code[0];
                            end
                            3'd2, 3'd3: begin
                                if (op_b == 32'd0) begin
                                    done_d = 1'b1;
                                end else begin
                                    rem_d  = 32'd0;
                                    quo_d  = a_abs;
                                    dvs_d  = b_abs;
                                    qneg_d = div_sgn && (op_a[31] ^ op_b[31]);
                                    rneg_d = div_sgn && op_a[31];
                                end
                            end
                            3'd4: begin
                                hi_d   = op_a;
                                done_d = 1'b1;
                            end
                            3'd5: begin
                                lo_d   = op_a;
                                done_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        {hi_d, lo_d} = uns_q ? prod_u : mul_res;
                        done_d       = 1'b1;
                    end
                end
                S_DIV: begin
                    rem_d = div_ge ? 32'(div_sh - {1'b0, dvs_q}) : div_sh[31:0];
                    quo_d = {quo_q[30:0], div_ge};
                end
                S_FIX: begin
                    lo_d   = qneg_q ? -quo_q : quo_q;
                    hi_d   = rneg_q ? -rem_q : rem_q;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
        mul_a = ma_q;
        mul_b = mb_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: two instances (MUL_CYCLES 1 and 3)
// share stimulus; a monitor pops expected HI/LO on every done pulse.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cancel;

    logic        busy1, done1, busy3, done3;
    logic [31:0] hi1, lo1, ma1, mb1, hi3, lo3, ma3, mb3;
    logic [63:0] res1, res3;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] q1[$];
    logic [63:0] q3[$];

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    assign res1 = smul(ma1, mb1);
    assign res3 = smul(ma3, mb3);

    muldiv_ctrl #(.MUL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .cancel(cancel), .busy(busy1), .done(done1),
        .hi(hi1), .lo(lo1), .mul_a(ma1), .mul_b(mb1), .mul_res(res1)
    );

    muldiv_ctrl #(.MUL_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .cancel(cancel), .busy(busy3), .done(done3),
        .hi(hi3), .lo(lo3), .mul_a(ma3), .mul_b(mb3), .mul_res(res3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest queued HI/LO
    always @(negedge clk) begin
        logic [63:0] e;
        chk("dut1 done_with_busy", 64'(done1 & busy1), 64'd0);
        chk("dut3 done_with_busy", 64'(done3 & busy3), 64'd0);
        if (done1 === 1'b1) begin
            chk("dut1 spurious_done", 64'(q1.size() == 0), 64'd0);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("dut1 hilo", {hi1, lo1}, e);
            end
        end
        if (done3 === 1'b1) begin
            chk("dut3 spurious_done", 64'(q3.size() == 0), 64'd0);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("dut3 hilo", {hi3, lo3}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        step();
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n1, output int n3, output logic d1, output logic d3);
        bit f1;
        bit f3;
        f1 = 0;
        f3 = 0;
        n1 = 0;
        n3 = 0;
        d1 = 1'b0;
        d3 = 1'b0;
        for (int k = 0; k < 100 && !(f1 && f3); k++) begin
            if (!f1) begin
                if (busy1) n1++;
                else begin f1 = 1; d1 = done1; end
            end
            if (!f3) begin
                if (busy3) n3++;
                else begin f3 = 1; d3 = done3; end
            end
            if (!(f1 && f3)) step();
        end
        chk("idle_timeout", {62'd0, f1, f3}, 64'd3);
    endtask

    task automatic do_op(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int en1, input int en3,
                         input logic [31:0] eh, input logic [31:0] el);
        int n1, n3;
        logic d1, d3;
        q1.push_back({eh, el});
        q3.push_back({eh, el});
        issue(op, a, b);
        wait_idle(n1, n3, d1, d3);
        chk({nm, " busy1_cycles"}, n1, en1);
        chk({nm, " busy3_cycles"}, n3, en3);
        chk({nm, " done1"}, d1, 1);
        chk({nm, " done3"}, d3, 1);
        chk({nm, " hilo1"}, {hi1, lo1}, {eh, el});
        chk({nm, " hilo3"}, {hi3, lo3}, {eh, el});
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        cancel   = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset hilo1", {hi1, lo1}, 64'd0);
        chk("reset hilo3", {hi3, lo3}, 64'd0);
        chk("reset mul3", {ma3, mb3}, 64'd0);
        chk("reset busy_done", {busy1, done1, busy3, done3}, 4'd0);

        do_op("mult", 3'd0, 32'hFFFFFFFE, 32'h3, 1, 3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3, 32'hFFFFFFFE, 32'h1);
        chk("multu mul3_ops", {ma3, mb3}, {32'hFFFFFFFF, 32'hFFFFFFFF});
        do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h2, 33, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu", 3'd3, 32'd100, 32'd7, 33, 33, 32'd2, 32'd14);
        do_op("div_wrap", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 33, 32'h0, 32'h80000000);
        chk("div keeps mul_ops", {ma1, mb1}, {32'hFFFFFFFF, 32'hFFFFFFFF});
        do_op("mthi", 3'd4, 32'h12345678, 32'h0, 0, 0, 32'h12345678, 32'h80000000);
        do_op("mtlo", 3'd5, 32'h12345678, 32'h0, 0, 0, 32'h12345678, 32'h12345678);
        do_op("divu_zero", 3'd3, 32'd100, 32'd0, 0, 0, 32'h12345678, 32'h12345678);

        // cancel in the 10th busy cycle, with an ignored op presented meanwhile
        issue(3'd2, 32'd1000, 32'd3);
        chk("cancel busy_started", busy1, 1);
        step();
        op_valid = 1'b1;
        op_code  = 3'd5;
        op_a     = 32'hDEADBEEF;
        step();
        step();
        op_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("cancel busy_before", {busy1, busy3}, 2'b11);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel busy_after", {busy1, busy3}, 2'b00);
        chk("cancel no_done", {done1, done3}, 2'b00);
        chk("cancel hilo1", {hi1, lo1}, {m_hi, m_lo});
        chk("cancel hilo3", {hi3, lo3}, {m_hi, m_lo});
        step();
        chk("cancel no_late_done", {done1, done3}, 2'b00);

        // cancel with op_valid in IDLE drops even MTHI
        op_valid = 1'b1;
        cancel   = 1'b1;
        op_code  = 3'd4;
        op_a     = 32'hAAAA5555;
        step();
        op_valid = 1'b0;
        cancel   = 1'b0;
        chk("idle_cancel done", {done1, done3}, 2'b00);
        step();
        chk("idle_cancel hi", {hi1, hi3}, {m_hi, m_hi});

        issue(3'd6, 32'h1, 32'h1);
        chk("reserved6 busy_done", {busy1, done1, busy3, done3}, 4'd0);
        issue(3'd7, 32'h1, 32'h1);
        chk("reserved7 busy_done", {busy1, done1, busy3, done3}, 4'd0);
        step();
        chk("reserved hilo", {hi1, lo1}, {m_hi, m_lo});

        do_op("mult_min", 3'd0, 32'h80000000, 32'h80000000, 1, 3, 32'h40000000, 32'h0);
        do_op("multu_msb", 3'd1, 32'h80000000, 32'h2, 1, 3, 32'h1, 32'h0);

        // reset in the 2nd cycle of a multiply: only dut1 has completed by then
        q1.push_back({32'h0, 32'd35});
        issue(3'd0, 32'd5, 32'd7);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset hilo1", {hi1, lo1}, 64'd0);
        chk("midreset hilo3", {hi3, lo3}, 64'd0);
        chk("midreset mul3", {ma3, mb3}, 64'd0);
        chk("midreset busy_done", {busy1, done1, busy3, done3}, 4'd0);
        step();
        step();
        chk("queue1 drained", q1.size(), 0);
        chk("queue3 drained", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
